// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter.
// Serialises one word per frame onto an idle-high line. Frame layout: start bit (0), DataBits data
// bits (LSB or MSB first), optional parity bit, StopBits stop bits (1). Bit timing comes from an
// external sample_trigger strobe; each bit is held for SamplesPerBit strobes.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   sample_trigger one-cycle strobe, SamplesPerBit strobes per bit period
//   data           word to send, sampled only on accept
//   start          level-sensitive request, accepted on an edge where ready=1
//   serial_data    UART line, idle 1
//   ready          1 = idle and able to accept
//   done           one-cycle pulse at the end of the last stop bit
//   parity_bit     parity of the latched word, valid while ready=0
module uart_tx_framed #(
  parameter int unsigned DataBits      = 8,
  parameter int unsigned SamplesPerBit = 16,
  parameter int unsigned ParityMode    = 0,
  parameter int unsigned StopBits      = 1,
  parameter bit          LsbFirst      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_trigger,
  input  logic [DataBits-1:0] data,
  input  logic                start,
  output logic                serial_data,
  output logic                ready,
  output logic                done,
  output logic                parity_bit
);

  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("uart_tx_framed: DataBits must be 5..9");
  end
  if (SamplesPerBit < 2 || SamplesPerBit > 64) begin : g_bad_samples
    $error("uart_tx_framed: SamplesPerBit must be 2..64");
  end
  if (ParityMode > 2) begin : g_bad_parity
    $error("uart_tx_framed: ParityMode must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
    $error("uart_tx_framed: StopBits must be 1 or 2");
  end

  localparam int unsigned CntW = (SamplesPerBit > 1) ? $clog2(SamplesPerBit) : 1;
  localparam logic [CntW-1:0] LastSample = CntW'(SamplesPerBit - 1);
  localparam logic [3:0]      LastData   = 4'(DataBits - 1);
  localparam logic            LastStop   = 1'(StopBits - 1);
  localparam bit              HasParity  = (ParityMode != 0);
  localparam bit              OddParity  = (ParityMode == 2);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e              state_q;
  logic [DataBits-1:0] shift_q;
  logic [CntW-1:0]     samp_q;
  logic [3:0]          bits_q;   // data bits still to send after the current one
  logic                stop_q;   // stop bits still to send after the current one

  logic                cur_bit;
  logic [DataBits-1:0] shift_next;
  logic                last_sample;
  logic                word_parity;

  // The bit leaving the shift register next, and the register after it has gone.
  always_comb begin
    cur_bit    = 1'b0;
    shift_next = '0;
    if (LsbFirst) begin
      cur_bit    = shift_q[0];
      shift_next = {1'b0, shift_q[DataBits-1:1]};
    end else begin
      cur_bit    = shift_q[DataBits-1];
      shift_next = {shift_q[DataBits-2:0], 1'b0};
    end
  end

  always_comb begin
    last_sample = sample_trigger && (samp_q == LastSample);
    word_parity = OddParity ? ~(^data) : (^data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      samp_q      <= '0;
      bits_q      <= '0;
      stop_q      <= 1'b0;
      serial_data <= 1'b1;
      ready       <= 1'b0;
      done        <= 1'b0;
      parity_bit  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          serial_data <= 1'b1;
          ready       <= 1'b1;
          // Accept only once ready is visible, so the first edge out of reset never accepts.
          if (ready && start) begin
            shift_q    <= data;
            parity_bit <= word_parity;
            ready      <= 1'b0;
            state_q    <= StWait;
          end
        end

        StWait: begin
          if (sample_trigger) begin
            serial_data <= 1'b0;
            samp_q      <= '0;
            state_q     <= StStart;
          end
        end

        StStart: begin
          if (last_sample) begin
            samp_q      <= '0;
            serial_data <= cur_bit;
            shift_q     <= shift_next;
            bits_q      <= LastData;
            state_q     <= StData;
          end else if (sample_trigger) begin
            samp_q <= samp_q + CntW'(1);
          end
        end

        StData: begin
          if (last_sample) begin
            samp_q <= '0;
            if (bits_q != 4'd0) begin
              bits_q      <= bits_q - 4'd1;
              serial_data <= cur_bit;
              shift_q     <= shift_next;
            end else if (HasParity) begin
              serial_data <= parity_bit;
              state_q     <= StParity;
            end else begin
              serial_data <= 1'b1;
              stop_q      <= LastStop;
              state_q     <= StStop;
            end
          end else if (sample_trigger) begin
            samp_q <= samp_q + CntW'(1);
          end
        end

        StParity: begin
          if (last_sample) begin
            samp_q      <= '0;
            serial_data <= 1'b1;
            stop_q      <= LastStop;
            state_q     <= StStop;
          end else if (sample_trigger) begin
            samp_q <= samp_q + CntW'(1);
          end
        end

        StStop: begin
          if (last_sample) begin
            samp_q <= '0;
            if (stop_q) begin
              stop_q <= 1'b0;
            end else begin
              // Ready returns on this edge so a held start begins the next frame without a gap.
              serial_data <= 1'b1;
              done        <= 1'b1;
              ready       <= 1'b1;
              state_q     <= StIdle;
            end
          end else if (sample_trigger) begin
            samp_q <= samp_q + CntW'(1);
          end
        end

        default: begin
          serial_data <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: three instances cover 8N1 LSB-first, 7O2 at 8 samples/bit
// and 9E1 MSB-first. Frames are checked sample by sample against hand-written bit streams.
module tb_uart_tx_framed;

  localparam int TrigPeriod = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [2:0] start = 3'b000;
  logic [7:0] d0 = 8'h00;
  logic [6:0] d1 = 7'h00;
  logic [8:0] d2 = 9'h000;
  logic [2:0] ser;
  logic [2:0] rdy;
  logic [2:0] dn;
  logic [2:0] par;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;

  always #5 clk = ~clk;

  // Trigger changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    if (tcnt == TrigPeriod - 1) begin
      tcnt <= 0;
      trig <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
      trig <= 1'b0;
    end
  end

  uart_tx_framed u_8n1 (
    .clk(clk), .rst(rst), .sample_trigger(trig), .data(d0), .start(start[0]),
    .serial_data(ser[0]), .ready(rdy[0]), .done(dn[0]), .parity_bit(par[0])
  );

  uart_tx_framed #(
    .DataBits(7), .SamplesPerBit(8), .ParityMode(2), .StopBits(2), .LsbFirst(1'b1)
  ) u_7o2 (
    .clk(clk), .rst(rst), .sample_trigger(trig), .data(d1), .start(start[1]),
    .serial_data(ser[1]), .ready(rdy[1]), .done(dn[1]), .parity_bit(par[1])
  );

  uart_tx_framed #(
    .DataBits(9), .SamplesPerBit(16), .ParityMode(1), .StopBits(1), .LsbFirst(1'b0)
  ) u_9e1 (
    .clk(clk), .rst(rst), .sample_trigger(trig), .data(d2), .start(start[2]),
    .serial_data(ser[2]), .ready(rdy[2]), .done(dn[2]), .parity_bit(par[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Raise start for one edge and confirm the word was taken.
  task automatic launch(input int idx, input string tag);
    @(negedge clk);
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    check({tag, ".accept_ready"}, {31'd0, rdy[idx]}, 32'd0);
  endtask

  // Called just after the accept edge. exp holds the frame with the first bit leftmost.
  task automatic check_frame(input int idx, input int nbits, input int spb,
                             input logic [15:0] exp, input string tag);
    int   k = -1;
    int   total = nbits * spb;
    int   bad_wait = 0;
    int   bad_ctl = 0;
    int   bad_bit[16];
    bit   fin = 1'b0;
    logic t;
    for (int b = 0; b < 16; b++) bad_bit[b] = 0;
    for (int c = 0; c < total * TrigPeriod + 100 && !fin; c++) begin
      @(posedge clk);
      t = trig;
      #1;
      if (t) k++;
      if (k == total) begin
        fin = 1'b1;
        check({tag, ".done"}, {31'd0, dn[idx]}, 32'd1);
        check({tag, ".ready_at_end"}, {31'd0, rdy[idx]}, 32'd1);
        check({tag, ".line_at_end"}, {31'd0, ser[idx]}, 32'd1);
      end else if (k < 0) begin
        if (ser[idx] !== 1'b1 || rdy[idx] !== 1'b0 || dn[idx] !== 1'b0) bad_wait++;
      end else begin
        if (ser[idx] !== exp[nbits - 1 - k / spb]) bad_bit[k / spb]++;
        if (rdy[idx] !== 1'b0 || dn[idx] !== 1'b0) bad_ctl++;
      end
    end
    check({tag, ".completed"}, {31'd0, fin}, 32'd1);
    check({tag, ".wait_phase"}, bad_wait, 0);
    check({tag, ".busy_ctl"}, bad_ctl, 0);
    for (int b = 0; b < nbits; b++) check($sformatf("%s.bit%0d", tag, b), bad_bit[b], 0);
  endtask

  task automatic idle_check(input int idx, input int cycles, input string tag);
    int bad = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (ser[idx] !== 1'b1 || rdy[idx] !== 1'b1 || dn[idx] !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int bad;
    int k;
    logic t;

    // stays_in_reset: start and data are ignored while rst is held.
    start = 3'b111;
    d0    = 8'hD5;
    d1    = 7'h55;
    d2    = 9'h1A5;
    bad   = 0;
    repeat (3000) begin
      @(posedge clk);
      #1;
      if (ser !== 3'b111 || rdy !== 3'b000 || dn !== 3'b000 || par !== 3'b000) bad++;
    end
    check("reset_hold", bad, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 3'b000;
    @(posedge clk);
    #1;
    check("ready_after_reset", {29'd0, rdy}, 32'h7);
    check("line_after_reset", {29'd0, ser}, 32'h7);

    // default_8n1: 8'hD5 -> 0,1,0,1,0,1,0,1,1,1
    d0 = 8'hD5;
    launch(0, "8n1");
    check_frame(0, 10, 16, 16'(10'b0101010111), "8n1");
    idle_check(0, 3000, "8n1_idle");

    // parity_and_stop: 7'h55 odd parity (four ones) -> parity 1, two stop bits.
    d1 = 7'h55;
    launch(1, "7o2");
    check("7o2.parity_out", {31'd0, par[1]}, 32'd1);
    check_frame(1, 11, 8, 16'(11'b01010101111), "7o2");
    idle_check(1, 50, "7o2_idle");

    // msb_first_9bit: 9'h1A5 MSB first, even parity (five ones) -> parity 1.
    d2 = 9'h1A5;
    launch(2, "9e1");
    check("9e1.parity_out", {31'd0, par[2]}, 32'd1);
    check_frame(2, 12, 16, 16'(12'b011010010111), "9e1");
    idle_check(2, 50, "9e1_idle");

    // busy_and_back_to_back: start held high, data swapped mid-frame.
    @(negedge clk);
    d0       = 8'hD5;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    check("b2b.accept_ready", {31'd0, rdy[0]}, 32'd0);
    fork
      check_frame(0, 10, 16, 16'(10'b0101010111), "b2b_first");
      begin
        repeat (200) @(negedge clk);
        d0 = 8'hBD;
      end
    join
    check_frame(0, 10, 16, 16'(10'b0101111011), "b2b_second");
    @(negedge clk);
    start[0] = 1'b0;
    @(posedge clk);
    #1;
    check("b2b.done_single", {31'd0, dn[0]}, 32'd0);
    idle_check(0, 100, "b2b_idle");

    // reset_mid_frame: 8'h0F puts a 0 on the line at sample 80 (frame bit 5).
    d0 = 8'h0F;
    launch(0, "rmf");
    k = -1;
    for (int c = 0; c < 1000 && k < 80; c++) begin
      @(posedge clk);
      t = trig;
      #1;
      if (t) k++;
    end
    check("rmf.reached_sample80", k, 80);
    check("rmf.line_low", {31'd0, ser[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rmf.line_idle", {31'd0, ser[0]}, 32'd1);
    check("rmf.ready_low", {31'd0, rdy[0]}, 32'd0);
    check("rmf.no_done", {31'd0, dn[0]}, 32'd0);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ser[0] !== 1'b1 || rdy[0] !== 1'b0 || dn[0] !== 1'b0) bad++;
    end
    check("rmf.hold", bad, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rmf.ready_after", {31'd0, rdy[0]}, 32'd1);
    check("rmf.no_done_after", {31'd0, dn[0]}, 32'd0);
    d0 = 8'hD5;
    launch(0, "rmf_fresh");
    check_frame(0, 10, 16, 16'(10'b0101010111), "rmf_fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
